esfa_cell_sequencer: RTL and testbench
======================================

// Module: esfa_cell_sequencer
// PURPOSE
//  Upstream controller for the ESFA MemoryCell array. Accepts one high-level
//  command at a time, broadcasts a 1-2 step selector sequence to all cells,
//  samples the reduced cell results and returns one response per command.
//  All cells share its drive bus; an external OR/priority reducer feeds cell_* results back.
// PARAMETERS
//  DW          8      width of handle/index/value/metadata/result buses
//  RESULT_LAT  1      wait cycles between a selector issue and result sampling (>=1)
//  SEL_IDLE    8'hFF  selector driven when idle; matches no cell op, so cells hold
// PORTS
//  clk              in   1   system clock, rising edge
//  rst_n            in   1   asynchronous active-low reset
//  cmd_valid        in   1   command present
//  cmd_ready        out  1   sequencer accepts command (IDLE only)
//  cmd_op           in   3   0 LOOKUP, 1 UPDATE, 2 CONGRUE, 3 RANK, 4-7 illegal
//  cmd_handle       in   DW  array handle
//  cmd_index        in   DW  element index
//  cmd_value        in   DW  element value (UPDATE)
//  cell_selector    out  8   broadcast op selector to all cells
//  cell_will_write  out  1   broadcast state-write enable
//  cell_handle      out  DW  broadcast handle
//  cell_index       out  DW  broadcast inserted_index
//  cell_value       out  DW  broadcast inserted_value
//  cell_metadata    out  DW  broadcast metadata
//  cell_is_metadata out  1   broadcast isMetadata
//  cell_any_bool    in   1   OR of all cell new_bool
//  cell_result      in   DW  reduced new_result_value
//  cell_context     in   DW  reduced new_context
//  rsp_valid        out  1   response present
//  rsp_ready        in   1   consumer accepts response
//  rsp_status       out  2   0 OK, 1 NOT_FOUND, 2 FULL, 3 ILLEGAL_OP
//  rsp_value        out  DW  returned value
//  rsp_context      out  DW  returned context
// BEHAVIOUR
//  Reset: state IDLE; cell_selector=SEL_IDLE; cell_will_write, cell_is_metadata=0;
//   all cell_* data, rsp_* =0; rsp_valid=0; cmd_ready=1. Cell contents untouched.
//  FSM: IDLE -> ISSUE1 -> WAIT1 -> [ISSUE2 -> WAIT2] -> RESP -> IDLE.
//  IDLE: cmd_ready=1; on cmd_valid capture op/handle/index/value; illegal op
//   goes straight to RESP with status 3, value/context 0, no cell activity.
//  ISSUEn: exactly one cycle with step selector/write on bus; all other cycles
//   bus holds SEL_IDLE, will_write=0. Data buses hold captured command throughout.
//  WAITn: RESULT_LAT cycles (down-counter); sample cell_* on last WAIT cycle.
//  Step tables (selector/will_write):
//   LOOKUP : 1/0. OK if any_bool, else NOT_FOUND; value=result, context=context.
//   UPDATE : 5/0 (markAvailableCell); any_bool=0 -> RESP FULL, skip step 2;
//            else 0/1 with metadata=sampled context, is_metadata=1; status OK,
//            value=step-2 result, context=step-2 context.
//   CONGRUE: 3/1 then 4/1; status OK; response from step 2.
//   RANK   : 6/0 then 7/0; value=step-1 result, context=step-2 context;
//            NOT_FOUND if either step any_bool=0.
//  Latency cmd accept -> rsp_valid: 1 step = 2+RESULT_LAT, 2 steps = 3+2*RESULT_LAT.
//  RESP: rsp_valid=1, rsp_* stable until rsp_valid&&rsp_ready; then IDLE next
//   cycle. cmd_ready=0 outside IDLE; no new command accepted same cycle as
//   response handshake.
//  Async reset mid-sequence: immediate return to reset values; a write selector
//   already issued is not retracted; pending response dropped.
//  Widths: no arithmetic; all fields pass through at DW bits unmodified.
// TESTING
//  1 Reset: rst_n low mid-UPDATE ISSUE2 -> selector=8'hFF, will_write=0, rsp_valid=0 same cycle.
//  2 LOOKUP h=3 i=5, model returns bool=1 val=8'h2A ctx=8'h07 -> sel 1 one cycle,
//    rsp OK/2A/07 at cycle 3 (RESULT_LAT=1).
//  3 UPDATE h=1 i=2 v=9, markAvailable ctx=8'h04 -> sel 5 then sel 0 with
//    will_write=1, metadata=04, is_metadata=1; rsp OK.
//  4 UPDATE with cell_any_bool=0 at step 1 -> no sel 0 issued; rsp status 2 (FULL).
//  5 cmd_op=6 -> no selector change, rsp status 3 one cycle after accept.
//  6 rsp_ready held low 5 cycles -> rsp fields stable, cmd_ready=0; release -> IDLE, next cmd accepted.

Source files
------------

// File: rtl/esfa_cell_sequencer.sv
// Upstream sequencer for the ESFA MemoryCell array: turns one command into a 1-2 step
// selector broadcast, samples the reduced cell results and returns a single response.
module esfa_cell_sequencer #(
  parameter int unsigned DW         = 8,
  parameter int unsigned RESULT_LAT = 1,
  parameter logic [7:0]  SEL_IDLE   = 8'hFF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [DW-1:0] cmd_handle,
  input  logic [DW-1:0] cmd_index,
  input  logic [DW-1:0] cmd_value,
  output logic [7:0]    cell_selector,
  output logic          cell_will_write,
  output logic [DW-1:0] cell_handle,
  output logic [DW-1:0] cell_index,
  output logic [DW-1:0] cell_value,
  output logic [DW-1:0] cell_metadata,
  output logic          cell_is_metadata,
  input  logic          cell_any_bool,
  input  logic [DW-1:0] cell_result,
  input  logic [DW-1:0] cell_context,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [1:0]    rsp_status,
  output logic [DW-1:0] rsp_value,
  output logic [DW-1:0] rsp_context
);

  localparam logic [2:0] OpLookup  = 3'd0;
  localparam logic [2:0] OpUpdate  = 3'd1;
  localparam logic [2:0] OpCongrue = 3'd2;
  localparam logic [2:0] OpRank    = 3'd3;

  localparam logic [1:0] StatusOk       = 2'd0;
  localparam logic [1:0] StatusNotFound = 2'd1;
  localparam logic [1:0] StatusFull     = 2'd2;
  localparam logic [1:0] StatusIllegal  = 2'd3;

  localparam int unsigned CntW = (RESULT_LAT > 1) ? $clog2(RESULT_LAT) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(RESULT_LAT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StIssue1,
    StWait1,
    StIssue2,
    StWait2,
    StResp
  } state_e;

  state_e        state_q, state_d;
  logic [2:0]    op_q, op_d;
  logic [DW-1:0] handle_q, handle_d;
  logic [DW-1:0] index_q, index_d;
  logic [DW-1:0] value_q, value_d;
  logic [DW-1:0] metadata_q, metadata_d;
  logic          is_metadata_q, is_metadata_d;
  logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
  logic [1:0]    status_q, status_d;
  logic [DW-1:0] rsp_value_q, rsp_value_d;
  logic [DW-1:0] rsp_context_q, rsp_context_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      op_q          <= '0;
      handle_q      <= '0;
      index_q       <= '0;
      value_q       <= '0;
      metadata_q    <= '0;
      is_metadata_q <= 1'b0;
      wait_cnt_q    <= '0;
      status_q      <= '0;
      rsp_value_q   <= '0;
      rsp_context_q <= '0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      handle_q      <= handle_d;
      index_q       <= index_d;
      value_q       <= value_d;
      metadata_q    <= metadata_d;
      is_metadata_q <= is_metadata_d;
      wait_cnt_q    <= wait_cnt_d;
      status_q      <= status_d;
      rsp_value_q   <= rsp_value_d;
      rsp_context_q <= rsp_context_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    handle_d      = handle_q;
    index_d       = index_q;
    value_d       = value_q;
    metadata_d    = metadata_q;
    is_metadata_d = is_metadata_q;
    wait_cnt_d    = wait_cnt_q;
    status_d      = status_q;
    rsp_value_d   = rsp_value_q;
    rsp_context_d = rsp_context_q;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          op_d          = cmd_op;
          handle_d      = cmd_handle;
          index_d       = cmd_index;
          value_d       = cmd_value;
          metadata_d    = '0;
          is_metadata_d = 1'b0;
          if (cmd_op[2]) begin
            // Ops 4-7 never touch the cells.
            status_d      = StatusIllegal;
            rsp_value_d   = '0;
            rsp_context_d = '0;
            state_d       = StResp;
          end else begin
            state_d = StIssue1;
          end
        end
      end

      StIssue1: begin
        wait_cnt_d = CntLoad;
        state_d    = StWait1;
      end

      StWait1: begin
        if (wait_cnt_q != '0) begin
          wait_cnt_d = wait_cnt_q - CntW'(1);
        end else begin
          rsp_value_d   = cell_result;
          rsp_context_d = cell_context;
          status_d      = cell_any_bool ? StatusOk : StatusNotFound;
          state_d       = StIssue2;
          case (op_q)
            OpLookup: state_d = StResp;
            OpUpdate: begin
              if (!cell_any_bool) begin
                status_d = StatusFull;
                state_d  = StResp;
              end else begin
                // Step 2 writes into the cell that markAvailableCell reported.
                metadata_d    = cell_context;
                is_metadata_d = 1'b1;
              end
            end
            default: ;
          endcase
        end
      end

      StIssue2: begin
        wait_cnt_d = CntLoad;
        state_d    = StWait2;
      end

      StWait2: begin
        if (wait_cnt_q != '0) begin
          wait_cnt_d = wait_cnt_q - CntW'(1);
        end else begin
          rsp_context_d = cell_context;
          state_d       = StResp;
          if (op_q == OpRank) begin
            // RANK keeps the step-1 value; either miss makes it NOT_FOUND.
            if (!cell_any_bool) status_d = StatusNotFound;
          end else begin
            rsp_value_d = cell_result;
            status_d    = StatusOk;
          end
        end
      end

      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cell_selector   = SEL_IDLE;
    cell_will_write = 1'b0;
    if (state_q == StIssue1) begin
      case (op_q)
        OpLookup:  cell_selector = 8'd1;
        OpUpdate:  cell_selector = 8'd5;
        OpCongrue: begin
          cell_selector   = 8'd3;
          cell_will_write = 1'b1;
        end
        OpRank:    cell_selector = 8'd6;
        default: ;
      endcase
    end else if (state_q == StIssue2) begin
      case (op_q)
        OpUpdate: begin
          cell_selector   = 8'd0;
          cell_will_write = 1'b1;
        end
        OpCongrue: begin
          cell_selector   = 8'd4;
          cell_will_write = 1'b1;
        end
        OpRank:    cell_selector = 8'd7;
        default: ;
      endcase
    end
  end

  assign cmd_ready        = (state_q == StIdle);
  assign rsp_valid        = (state_q == StResp);
  assign cell_handle      = handle_q;
  assign cell_index       = index_q;
  assign cell_value       = value_q;
  assign cell_metadata    = metadata_q;
  assign cell_is_metadata = is_metadata_q;
  assign rsp_status       = status_q;
  assign rsp_value        = rsp_value_q;
  assign rsp_context      = rsp_context_q;

endmodule

// File: tb/tb_esfa_cell_sequencer.sv
// Bench for esfa_cell_sequencer: a behavioural cell-array responder plus a per-command
// reference model of selector sequence, timing and response.
module tb_esfa_cell_sequencer;
  localparam int unsigned DW = 8;
  localparam int unsigned RL = 1;
  localparam logic [7:0]  SelIdle = 8'hFF;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid, cmd_ready;
  logic [2:0]    cmd_op;
  logic [DW-1:0] cmd_handle, cmd_index, cmd_value;
  logic [7:0]    cell_selector;
  logic          cell_will_write, cell_is_metadata;
  logic [DW-1:0] cell_handle, cell_index, cell_value, cell_metadata;
  logic          cell_any_bool;
  logic [DW-1:0] cell_result, cell_context;
  logic          rsp_valid, rsp_ready;
  logic [1:0]    rsp_status;
  logic [DW-1:0] rsp_value, rsp_context;

  esfa_cell_sequencer #(.DW(DW), .RESULT_LAT(RL), .SEL_IDLE(SelIdle)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_handle(cmd_handle), .cmd_index(cmd_index), .cmd_value(cmd_value),
    .cell_selector(cell_selector), .cell_will_write(cell_will_write),
    .cell_handle(cell_handle), .cell_index(cell_index), .cell_value(cell_value),
    .cell_metadata(cell_metadata), .cell_is_metadata(cell_is_metadata),
    .cell_any_bool(cell_any_bool), .cell_result(cell_result), .cell_context(cell_context),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status),
    .rsp_value(rsp_value), .rsp_context(rsp_context)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Cell-array answers for step 1 / step 2 of the next command.
  logic          cb[2];
  logic [DW-1:0] cr[2];
  logic [DW-1:0] cc[2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic run_cmd(input logic [2:0] op, input logic [DW-1:0] h, input logic [DW-1:0] i,
                         input logic [DW-1:0] v, input int hold);
    int            exp_n, exp_rsp_cyc, n_steps, cyc, pend, rsp_cyc;
    logic [7:0]    exp_sel[2];
    logic          exp_ww[2];
    logic [1:0]    exp_st;
    logic [DW-1:0] exp_val, exp_ctx;
    bit            chk_data, got, bad_ww, bad_ready;
    logic [7:0]    s_sel[2];
    logic          s_ww[2], s_ism[2];
    logic [DW-1:0] s_meta[2], s_h[2], s_i[2], s_v[2];
    int            s_cyc[2];

    // Reference model: expected steps and response from the command rules.
    exp_sel = '{SelIdle, SelIdle};
    exp_ww  = '{1'b0, 1'b0};
    exp_val = '0;
    exp_ctx = '0;
    chk_data = 1'b1;
    case (op)
      3'd0: begin
        exp_n = 1; exp_sel[0] = 8'd1;
        exp_st = cb[0] ? 2'd0 : 2'd1; exp_val = cr[0]; exp_ctx = cc[0];
      end
      3'd1: begin
        exp_sel[0] = 8'd5; exp_sel[1] = 8'd0; exp_ww[1] = 1'b1;
        if (cb[0]) begin
          exp_n = 2; exp_st = 2'd0; exp_val = cr[1]; exp_ctx = cc[1];
        end else begin
          exp_n = 1; exp_st = 2'd2; chk_data = 1'b0;
        end
      end
      3'd2: begin
        exp_n = 2; exp_sel[0] = 8'd3; exp_ww[0] = 1'b1; exp_sel[1] = 8'd4; exp_ww[1] = 1'b1;
        exp_st = 2'd0; exp_val = cr[1]; exp_ctx = cc[1];
      end
      3'd3: begin
        exp_n = 2; exp_sel[0] = 8'd6; exp_sel[1] = 8'd7;
        exp_st = (cb[0] && cb[1]) ? 2'd0 : 2'd1; exp_val = cr[0]; exp_ctx = cc[1];
      end
      default: begin
        exp_n = 0; exp_st = 2'd3;
      end
    endcase
    exp_rsp_cyc = (exp_n == 0) ? 1 : (exp_n == 1) ? 2 + RL : 3 + 2 * RL;

    @(negedge clk);
    check("cmd_ready_idle", cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_op = op; cmd_handle = h; cmd_index = i; cmd_value = v;
    @(posedge clk);

    n_steps = 0; cyc = 0; pend = -1; got = 1'b0; bad_ww = 1'b0; bad_ready = 1'b0; rsp_cyc = 0;
    while (!got && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        cmd_valid = 1'b0; cmd_handle = ~h; cmd_index = ~i; cmd_value = ~v;
      end
      if (pend >= 0) begin
        cell_any_bool = cb[pend]; cell_result = cr[pend]; cell_context = cc[pend];
        pend = -1;
      end
      if (cmd_ready !== 1'b0) bad_ready = 1'b1;
      if (rsp_valid === 1'b1) begin
        got = 1'b1; rsp_cyc = cyc;
      end else if (cell_selector !== SelIdle) begin
        if (n_steps < 2) begin
          s_sel[n_steps] = cell_selector; s_ww[n_steps] = cell_will_write;
          s_ism[n_steps] = cell_is_metadata; s_meta[n_steps] = cell_metadata;
          s_h[n_steps] = cell_handle; s_i[n_steps] = cell_index; s_v[n_steps] = cell_value;
          s_cyc[n_steps] = cyc; pend = n_steps;
          // Cells answer only after the issue edge; drive the opposite until then.
          cell_any_bool = ~cb[n_steps]; cell_result = ~cr[n_steps]; cell_context = ~cc[n_steps];
        end
        n_steps++;
      end else if (cell_will_write !== 1'b0) begin
        bad_ww = 1'b1;
      end
    end

    check("rsp_arrived", got, 1'b1);
    check("step_count", n_steps, exp_n);
    check("rsp_latency", rsp_cyc, exp_rsp_cyc);
    check("no_idle_write", bad_ww, 1'b0);
    check("cmd_ready_busy", bad_ready, 1'b0);
    for (int k = 0; k < 2; k++) begin
      if (k < exp_n && k < n_steps) begin
        check("step_sel", s_sel[k], exp_sel[k]);
        check("step_will_write", s_ww[k], exp_ww[k]);
        check("step_cycle", s_cyc[k], (k == 0) ? 1 : 2 + RL);
        check("bus_handle", s_h[k], h);
        check("bus_index", s_i[k], i);
        check("bus_value", s_v[k], v);
        check("bus_is_metadata", s_ism[k], (op == 3'd1 && k == 1) ? 1'b1 : 1'b0);
        if (op == 3'd1 && k == 1) check("bus_metadata", s_meta[k], cc[0]);
      end
    end

    check("rsp_status", rsp_status, exp_st);
    if (chk_data) begin
      check("rsp_value", rsp_value, exp_val);
      check("rsp_context", rsp_context, exp_ctx);
    end
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check("hold_valid", rsp_valid, 1'b1);
      check("hold_cmd_ready", cmd_ready, 1'b0);
      check("hold_status", rsp_status, exp_st);
      if (chk_data) begin
        check("hold_value", rsp_value, exp_val);
        check("hold_context", rsp_context, exp_ctx);
      end
    end
    // Offer a command during the handshake cycle; it must not be taken.
    rsp_ready = 1'b1; cmd_valid = 1'b1; cmd_op = 3'd0;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0; cmd_valid = 1'b0;
    check("post_rsp_valid", rsp_valid, 1'b0);
    check("post_rsp_idle", cmd_ready, 1'b1);
    check("post_rsp_sel", cell_selector, SelIdle);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    cmd_valid = 1'b0; cmd_op = '0; cmd_handle = '0; cmd_index = '0; cmd_value = '0;
    cell_any_bool = 1'b0; cell_result = '0; cell_context = '0; rsp_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_sel", cell_selector, SelIdle);
    check("rst_ww", cell_will_write, 1'b0);
    check("rst_ism", cell_is_metadata, 1'b0);
    check("rst_handle", cell_handle, 8'h00);
    check("rst_meta", cell_metadata, 8'h00);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_fields", {rsp_status, rsp_value, rsp_context}, 18'h0);
    check("rst_cmd_ready", cmd_ready, 1'b1);
    rst_n = 1'b1;

    // Reset asserted while UPDATE step 2 is on the bus
    @(negedge clk);
    cell_any_bool = 1'b1; cell_context = 8'h04;
    cmd_valid = 1'b1; cmd_op = 3'd1; cmd_handle = 8'd1; cmd_index = 8'd2; cmd_value = 8'd9;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int w = 0; w < 10 && cell_selector !== 8'h00; w++) @(negedge clk);
    check("rst_mid_reach_issue2", cell_selector, 8'h00);
    check("rst_mid_write_issued", cell_will_write, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_sel", cell_selector, SelIdle);
    check("rst_mid_ww", cell_will_write, 1'b0);
    check("rst_mid_rsp_valid", rsp_valid, 1'b0);
    check("rst_mid_cmd_ready", cmd_ready, 1'b1);
    check("rst_mid_ism", cell_is_metadata, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // LOOKUP hit
    cb = '{1'b1, 1'b0}; cr = '{8'h2A, 8'h00}; cc = '{8'h07, 8'h00};
    run_cmd(3'd0, 8'd3, 8'd5, 8'd0, 0);
    // UPDATE with a free cell
    cb = '{1'b1, 1'b1}; cr = '{8'h11, 8'h5C}; cc = '{8'h04, 8'h3E};
    run_cmd(3'd1, 8'd1, 8'd2, 8'd9, 1);
    // UPDATE with no free cell
    cb = '{1'b0, 1'b1}; cr = '{8'h11, 8'h22}; cc = '{8'h33, 8'h44};
    run_cmd(3'd1, 8'd1, 8'd3, 8'd7, 0);
    // Illegal op
    run_cmd(3'd6, 8'hA5, 8'h5A, 8'hC3, 0);
    // Consumer stalls for 5 cycles
    cb = '{1'b0, 1'b0}; cr = '{8'h99, 8'h00}; cc = '{8'h66, 8'h00};
    run_cmd(3'd0, 8'hF0, 8'h0F, 8'h00, 5);
    // CONGRUE and RANK, hit and step-2 miss
    cb = '{1'b0, 1'b1}; cr = '{8'h01, 8'hE7}; cc = '{8'h02, 8'h7E};
    run_cmd(3'd2, 8'd4, 8'd8, 8'd12, 2);
    cb = '{1'b1, 1'b1}; cr = '{8'hB4, 8'h4B}; cc = '{8'hC2, 8'h2C};
    run_cmd(3'd3, 8'd2, 8'd6, 8'd0, 0);
    cb = '{1'b1, 1'b0}; cr = '{8'h81, 8'h18}; cc = '{8'h92, 8'h29};
    run_cmd(3'd3, 8'd2, 8'd7, 8'd0, 1);

    // Random commands
    for (int n = 0; n < 40; n++) begin
      logic [2:0] rop;
      rop = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      for (int k = 0; k < 2; k++) begin
        cb[k] = ($urandom_range(0, 3) != 0);
        cr[k] = 8'($urandom);
        cc[k] = 8'($urandom);
      end
      run_cmd(rop, 8'($urandom), 8'($urandom), 8'($urandom), $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
